load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 MEM_LAT, 1, memory read latency in cycles (legal 1..4) from o_mem_ren high to i_mem_rd valid.
REQ-002 i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_req  input  1  request strobe; sampled only while o_ready=1.
REQ-005 i_we  input  1  1=store, 0=load.
REQ-006 i_funct3  input  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; all others illegal.
REQ-007 i_addr  input  32  byte address.
REQ-008 i_wdata  input  32  store data, LSB-justified.
REQ-009 o_ready  output  1  high only in IDLE.
REQ-010 o_valid  output  1  one-cycle completion pulse.
REQ-011 o_err  output  1  qualifies o_valid; access rejected, no memory enable issued.
REQ-012 o_rdata  output  32  extended load result; held until next successful load.
REQ-013 o_mem_addr  output  32  word address, bits [1:0] always 0.
REQ-014 o_mem_wd  output  32  store data replicated onto byte lanes.
REQ-015 o_mem_wen  output  4  byte write enables.
REQ-016 o_mem_ren  output  1  read enable.
REQ-017 i_mem_rd  input  32  memory read word.

Function
REQ-018 FSM states IDLE, WRITE, READ, DONE; only one request in flight; i_req outside IDLE ignored, never queued.
REQ-019 IDLE + i_req: register we/funct3/addr/wdata; illegal access -> DONE with error; store -> WRITE; load -> READ.
REQ-020 WRITE lasts one cycle: wen = B 0001<<a[1:0], H 0011<<a[1:0], W 1111; wd = {4{b}}, {2{h}}, word; then DONE.
REQ-021 READ holds o_mem_ren=1 for exactly MEM_LAT cycles (counter); on last cycle capture i_mem_rd, select lane by offset, extend; then DONE.
REQ-022 Extension: B/H sign-extend from bit 7/15, BU/HU zero-extend, W unmodified.
REQ-023 DONE: o_valid=1 one cycle, o_ready=0, then IDLE; store latency req->o_valid 2 cycles, load MEM_LAT+1.
REQ-024 o_mem_wen=0 outside WRITE, o_mem_ren=0 outside READ, both decoded from state; o_mem_addr/o_mem_wd hold registered request.
REQ-025 Store or error completion leaves o_rdata unchanged; back-to-back requests accepted the cycle after DONE.

Reset
REQ-026 i_rst_n low asynchronously forces IDLE, counter 0, o_valid 0, o_err 0, o_rdata 0, o_mem_addr/o_mem_wd 0.
REQ-027 Reset mid-WRITE/READ abandons the access: wen/ren drop immediately, no o_valid ever issued for it.

Configuration
REQ-028 LSU_MISALIGN_TRAP_EN defined: H with a[0]=1 or W with a[1:0]!=0 completes with o_err=1 and no memory access.
REQ-029 LSU_MISALIGN_TRAP_EN undefined: offset forced aligned (H uses a[1] only, W ignores a[1:0]); o_err only for illegal funct3.

Structure
REQ-030 Package lsu_pkg holds funct3 codes, FSM state type, MEM_LAT bounds.
REQ-031 Sub-module lsu_lane: combinational wen/wd generation and read lane extract/extend; FSM and registers stay in load_store_unit.

Verification
REQ-032 SB addr 0x07 wdata 0xA5 -> next cycle wen=1000, wd=0xA5A5A5A5, mem_addr=0x04; o_valid following cycle, o_err=0.
REQ-033 SH addr 0x12 wdata 0xBEEF -> wen=1100, wd=0xBEEFBEEF, mem_addr=0x10.
REQ-034 Word 0x8070FF11 at 0x04: LB 0x05 -> 0xFFFFFFFF; LBU 0x05 -> 0x000000FF; LH 0x06 -> 0xFFFF8070; LHU 0x06 -> 0x00008070; o_valid at req+2 (MEM_LAT=1), req+4 (MEM_LAT=3).
REQ-035 LW addr 0x06: macro defined -> o_err=1, ren/wen never high; undefined -> o_rdata=0x8070FF11.
REQ-036 funct3=011 load or store -> o_err=1, no memory enables, both builds.
REQ-037 MEM_LAT=3, reset pulsed in 2nd READ cycle -> ren falls immediately, o_ready=1 after release, no o_valid.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM state type, latency bounds.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 4;

  typedef enum logic [1:0] {
    StIdle,
    StWrite,
    StRead,
    StDone
  } lsu_state_e;

  function automatic logic funct3_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_lane.sv
// Combinational byte-lane logic: store enables/replication and load lane extract/extension.
module lsu_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rd,
  output logic [3:0]  wen,
  output logic [31:0] wd,
  output logic [31:0] rdata
);

  logic [1:0]  hoff;
  logic [31:0] b_shift;
  logic [31:0] h_shift;

  // Halfwords only ever use lane 0 or 2; misaligned halves are trapped or forced aligned upstream.
  assign hoff    = {offset[1], 1'b0};
  assign b_shift = rd >> {offset, 3'b000};
  assign h_shift = rd >> {hoff, 3'b000};

  always_comb begin
    wen   = 4'b0000;
    wd    = wdata;
    rdata = rd;
    case (funct3)
      F3_B, F3_BU: begin
        wen   = 4'b0001 << offset;
        wd    = {4{wdata[7:0]}};
        rdata = (funct3 == F3_BU) ? {24'h0, b_shift[7:0]} : {{24{b_shift[7]}}, b_shift[7:0]};
      end
      F3_H, F3_HU: begin
        wen   = 4'b0011 << hoff;
        wd    = {2{wdata[15:0]}};
        rdata = (funct3 == F3_HU) ? {16'h0, h_shift[15:0]} : {{16{h_shift[15]}}, h_shift[15:0]};
      end
      F3_W: begin
        wen = 4'b1111;
      end
      default: begin
        wen = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with fixed-latency memory reads.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned H/W accesses instead of forcing alignment.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_ready,
  output logic        o_valid,
  output logic        o_err,
  output logic [31:0] o_rdata,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wd,
  output logic [3:0]  o_mem_wen,
  output logic        o_mem_ren,
  input  logic [31:0] i_mem_rd
);

  localparam logic [2:0] LastCnt = 3'(MEM_LAT - 1);

  lsu_state_e  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, err_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic        accept, misalign, req_err;
  logic [3:0]  lane_wen;
  logic [31:0] lane_wd, lane_rdata;

  assign accept = (state_q == StIdle) && i_req;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = (((i_funct3 == F3_H) || (i_funct3 == F3_HU)) && i_addr[0]) ||
                    ((i_funct3 == F3_W) && (i_addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign req_err = !funct3_legal(i_funct3) || misalign;

  lsu_lane u_lane (
    .funct3 (funct3_q),
    .offset (addr_q[1:0]),
    .wdata  (wdata_q),
    .rd     (i_mem_rd),
    .wen    (lane_wen),
    .wd     (lane_wd),
    .rdata  (lane_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 3'd0;
        if (i_req) begin
          if (req_err) begin
            state_d = StDone;
          end else if (i_we) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StWrite: state_d = StDone;
      StRead: begin
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      we_q     <= 1'b0;
      err_q    <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      rdata_q  <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q     <= i_we;
        err_q    <= req_err;
        funct3_q <= i_funct3;
        addr_q   <= i_addr;
        wdata_q  <= i_wdata;
      end
      if ((state_q == StRead) && (cnt_q == LastCnt)) begin
        rdata_q <= lane_rdata;
      end
    end
  end

  assign o_ready    = (state_q == StIdle);
  assign o_valid    = (state_q == StDone);
  assign o_err      = (state_q == StDone) && err_q;
  assign o_rdata    = rdata_q;
  assign o_mem_addr = {addr_q[31:2], 2'b00};
  assign o_mem_wd   = lane_wd;
  assign o_mem_wen  = (state_q == StWrite) ? lane_wen : 4'b0000;
  assign o_mem_ren  = (state_q == StRead);

  // we_q is kept for observability of the in-flight request; direction is encoded in the state.
  logic unused_we;
  assign unused_we = we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a fixed-latency memory model (MEM_LAT = 3).
module tb_load_store_unit;

  localparam int unsigned MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req = 1'b0, i_we = 1'b0;
  logic [2:0]  i_funct3 = 3'd0;
  logic [31:0] i_addr = 32'h0, i_wdata = 32'h0;
  logic        o_ready, o_valid, o_err, o_mem_ren;
  logic [31:0] o_rdata, o_mem_addr, o_mem_wd, mem_rd;
  logic [3:0]  o_mem_wen;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_LAT(MEM_LAT)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (i_req),
    .i_we       (i_we),
    .i_funct3   (i_funct3),
    .i_addr     (i_addr),
    .i_wdata    (i_wdata),
    .o_ready    (o_ready),
    .o_valid    (o_valid),
    .o_err      (o_err),
    .o_rdata    (o_rdata),
    .o_mem_addr (o_mem_addr),
    .o_mem_wd   (o_mem_wd),
    .o_mem_wen  (o_mem_wen),
    .o_mem_ren  (o_mem_ren),
    .i_mem_rd   (mem_rd)
  );

  // Memory returns real data only on the MEM_LAT-th consecutive read-enable cycle.
  logic [31:0] mem [0:15];
  int ren_run = 0, ren_cycles = 0, wen_cycles = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ren_run <= 0;
    else        ren_run <= o_mem_ren ? ren_run + 1 : 0;
  end
  always @(posedge clk) begin
    if (o_mem_ren) ren_cycles <= ren_cycles + 1;
    if (o_mem_wen != 4'b0000) wen_cycles <= wen_cycles + 1;
  end
  assign mem_rd = (o_mem_ren && (ren_run == int'(MEM_LAT) - 1)) ? mem[o_mem_addr[5:2]]
                                                                 : 32'hDEAD_BEEF;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  wen;
    logic [31:0] wd;
    logic [31:0] maddr;
  } exp_t;

  typedef struct {
    logic        timeout;
    logic        ready;
    logic        err;
    logic [31:0] rdata;
    int          lat;
    logic [3:0]  wen;
    logic [31:0] wd;
    logic [31:0] maddr;
    int          ren_n;
    int          wen_n;
  } obs_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] model_rdata = 32'h0;

  task automatic drive_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, output obs_t o);
    int r0, w0;
    o.timeout = 1'b1; o.err = 1'b0; o.rdata = 32'h0; o.lat = 0;
    o.wen = 4'b0; o.wd = 32'h0; o.maddr = 32'h0;
    @(negedge clk);
    o.ready = o_ready;
    r0 = ren_cycles; w0 = wen_cycles;
    i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_wdata = wdata;
    @(posedge clk);
    #1 i_req = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (k == 1) begin
        o.wen = o_mem_wen; o.wd = o_mem_wd; o.maddr = o_mem_addr;
      end
      if (o_valid) begin
        o.lat = k; o.err = o_err; o.rdata = o_rdata; o.timeout = 1'b0;
        break;
      end
    end
    o.ren_n = ren_cycles - r0;
    o.wen_n = wen_cycles - w0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got ready=%b valid=%b err=%b want 1 0 0", o_ready, o_valid, o_err);
    end
    n_cmp++;
    if (o_rdata !== 32'h0 || o_mem_addr !== 32'h0 || o_mem_wd !== 32'h0) begin
      n_bad++;
      $display("FAIL reset_data: got rdata=%h addr=%h wd=%h want all 0", o_rdata, o_mem_addr,
               o_mem_wd);
    end
    n_cmp++;
    if (o_mem_wen !== 4'b0 || o_mem_ren !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_en: got wen=%b ren=%b want 0000 0", o_mem_wen, o_mem_ren);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_store();
    logic [2:0]  f3 [3]  = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ad [3]  = '{32'h07, 32'h12, 32'h08};
    logic [31:0] wv [3]  = '{32'hA5, 32'hBEEF, 32'h1234_5678};
    logic [3:0]  ew [3]  = '{4'b1000, 4'b1100, 4'b1111};
    logic [31:0] ewd [3] = '{32'hA5A5_A5A5, 32'hBEEF_BEEF, 32'h1234_5678};
    logic [31:0] ema [3] = '{32'h04, 32'h10, 32'h08};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      sb.push_back('{err: 1'b0, rdata: model_rdata, lat: 2, wen: ew[i], wd: ewd[i],
                     maddr: ema[i]});
      drive_txn(1'b1, f3[i], ad[i], wv[i], o);
      e = sb.pop_front();
      n_cmp++;
      if (o.timeout || o.lat != e.lat) begin
        n_bad++;
        $display("FAIL store[%0d] latency: got %0d (timeout=%b) want %0d", i, o.lat, o.timeout,
                 e.lat);
      end
      n_cmp++;
      if (o.wen !== e.wen || o.wd !== e.wd || o.maddr !== e.maddr) begin
        n_bad++;
        $display("FAIL store[%0d] mem: got wen=%b wd=%h addr=%h want wen=%b wd=%h addr=%h", i,
                 o.wen, o.wd, o.maddr, e.wen, e.wd, e.maddr);
      end
      n_cmp++;
      if (o.err !== e.err || o.rdata !== e.rdata || o.wen_n != 1 || o.ren_n != 0) begin
        n_bad++;
        $display("FAIL store[%0d] status: got err=%b rdata=%h wcyc=%0d rcyc=%0d want 0 %h 1 0",
                 i, o.err, o.rdata, o.wen_n, o.ren_n, e.rdata);
      end
    end
  endtask

  task automatic test_load();
    logic [2:0]  f3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000};
    logic [31:0] ad [6] = '{32'h05, 32'h05, 32'h06, 32'h06, 32'h04, 32'h04};
    logic [31:0] er [6] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8070, 32'h0000_8070,
                            32'h8070_FF11, 32'h0000_0011};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{err: 1'b0, rdata: er[i], lat: int'(MEM_LAT) + 1, wen: 4'b0, wd: 32'h0,
                     maddr: 32'h04});
      drive_txn(1'b0, f3[i], ad[i], 32'h0, o);
      e = sb.pop_front();
      model_rdata = e.rdata;
      n_cmp++;
      if (o.timeout || o.lat != e.lat || o.err !== e.err) begin
        n_bad++;
        $display("FAIL load[%0d] timing: got lat=%0d err=%b (timeout=%b) want lat=%0d err=0", i,
                 o.lat, o.err, o.timeout, e.lat);
      end
      n_cmp++;
      if (o.rdata !== e.rdata) begin
        n_bad++;
        $display("FAIL load[%0d] rdata: got %h want %h", i, o.rdata, e.rdata);
      end
      n_cmp++;
      if (o.ren_n != int'(MEM_LAT) || o.wen_n != 0 || o.maddr !== e.maddr) begin
        n_bad++;
        $display("FAIL load[%0d] mem: got rcyc=%0d wcyc=%0d addr=%h want %0d 0 %h", i, o.ren_n,
                 o.wen_n, o.maddr, MEM_LAT, e.maddr);
      end
    end
  endtask

  task automatic test_errors();
    logic        we [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  f3 [3] = '{3'b011, 3'b011, 3'b010};
    logic [31:0] ad [3] = '{32'h04, 32'h04, 32'h06};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 3; i++) begin
`ifndef LSU_MISALIGN_TRAP_EN
      if (i == 2) begin
        sb.push_back('{err: 1'b0, rdata: 32'h8070_FF11, lat: int'(MEM_LAT) + 1, wen: 4'b0,
                       wd: 32'h0, maddr: 32'h04});
      end else
`endif
      sb.push_back('{err: 1'b1, rdata: model_rdata, lat: 1, wen: 4'b0, wd: 32'h0,
                     maddr: 32'h0});
      drive_txn(we[i], f3[i], ad[i], 32'hFFFF_FFFF, o);
      e = sb.pop_front();
      model_rdata = e.rdata;
      n_cmp++;
      if (o.timeout || o.lat != e.lat || o.err !== e.err) begin
        n_bad++;
        $display("FAIL error[%0d] status: got lat=%0d err=%b (timeout=%b) want lat=%0d err=%b",
                 i, o.lat, o.err, o.timeout, e.lat, e.err);
      end
      n_cmp++;
      if (o.rdata !== e.rdata) begin
        n_bad++;
        $display("FAIL error[%0d] rdata: got %h want %h", i, o.rdata, e.rdata);
      end
      n_cmp++;
      if (e.err && (o.ren_n != 0 || o.wen_n != 0)) begin
        n_bad++;
        $display("FAIL error[%0d] enables: got rcyc=%0d wcyc=%0d want 0 0", i, o.ren_n, o.wen_n);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o;
    exp_t e;
    int   w0;
    logic saw_valid;
    sb.push_back('{err: 1'b0, rdata: model_rdata, lat: 2, wen: 4'b1000, wd: 32'h5A5A_5A5A,
                   maddr: 32'h0});
    drive_txn(1'b1, 3'b000, 32'h03, 32'h5A, o);
    e = sb.pop_front();
    n_cmp++;
    if (o.wen !== e.wen || o.wd !== e.wd || o.lat != e.lat) begin
      n_bad++;
      $display("FAIL b2b store: got wen=%b wd=%h lat=%0d want %b %h %0d", o.wen, o.wd, o.lat,
               e.wen, e.wd, e.lat);
    end
    sb.push_back('{err: 1'b0, rdata: 32'h0000_0011, lat: int'(MEM_LAT) + 1, wen: 4'b0,
                   wd: 32'h0, maddr: 32'h04});
    drive_txn(1'b0, 3'b000, 32'h04, 32'h0, o);
    e = sb.pop_front();
    model_rdata = e.rdata;
    n_cmp++;
    if (!o.ready || o.lat != e.lat || o.rdata !== e.rdata) begin
      n_bad++;
      $display("FAIL b2b load: got ready=%b lat=%0d rdata=%h want 1 %0d %h", o.ready, o.lat,
               o.rdata, e.lat, e.rdata);
    end
    // Hold i_req with a store while busy: it must be ignored, not queued.
    @(negedge clk);
    w0 = wen_cycles;
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h04;
    @(posedge clk);
    #1 i_we = 1'b1; i_funct3 = 3'b000; i_addr = 32'h0;
    saw_valid = 1'b0;
    for (int k = 1; k <= int'(MEM_LAT) + 1; k++) begin
      @(negedge clk);
      if (o_valid) saw_valid = 1'b1;
    end
    i_req = 1'b0;
    model_rdata = 32'h8070_FF11;
    n_cmp++;
    if (!saw_valid || o_rdata !== model_rdata) begin
      n_bad++;
      $display("FAIL busy_ignore load: got valid=%b rdata=%h want 1 %h", saw_valid, o_rdata,
               model_rdata);
    end
    @(negedge clk);
    n_cmp++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL valid_pulse: got valid=%b ready=%b want 0 1", o_valid, o_ready);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (wen_cycles != w0) begin
      n_bad++;
      $display("FAIL busy_ignore store: got %0d write cycles want 0", wen_cycles - w0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic saw_valid;
    @(negedge clk);
    i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h04;
    @(posedge clk);
    #1 i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (o_mem_ren !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_read ren_before: got %b want 1", o_mem_ren);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_mem_ren !== 1'b0 || o_mem_wen !== 4'b0 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_read abort: got ren=%b wen=%b valid=%b want 0 0000 0", o_mem_ren,
               o_mem_wen, o_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (o_valid) saw_valid = 1'b1;
    end
    n_cmp++;
    if (saw_valid || o_ready !== 1'b1 || o_rdata !== 32'h0) begin
      n_bad++;
      $display("FAIL mid_read after: got valid_seen=%b ready=%b rdata=%h want 0 1 0", saw_valid,
               o_ready, o_rdata);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
    mem[1] = 32'h8070_FF11;
    test_reset();
    test_store();
    test_load();
    test_errors();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
